// File: rtl/seq_serializer_if.sv
// Signal bundle between the button/switch stimulus side and the serializer.
// The serializer connects through the slave modport and the stimulus side through the master modport.
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic             start_btn;
    logic [WIDTH-1:0] pattern_in;
    logic             loop_en;
    logic             serial_out;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic [3:0]       bit_idx;

    modport master (
        output start_btn, pattern_in, loop_en,
        input  serial_out, bit_valid, busy, done, bit_idx
    );

    modport slave (
        input  start_btn, pattern_in, loop_en,
        output serial_out, bit_valid, busy, done, bit_idx
    );
endinterface

// File: rtl/seq_serializer.sv
// Debounces a push-button and, on a clean press, shifts a switch pattern out MSB-first,
// holding each bit for TICK_DIV clocks; optionally loops, re-sampling the pattern per pass.
module seq_serializer #(
    parameter int WIDTH      = 8,
    parameter int TICK_DIV   = 25_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_s_n,
    seq_serializer_if.slave  ser
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int IDX_W  = $clog2(WIDTH);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    logic             sync_ff;
    logic             start_sync;
    logic             start_db;
    logic             start_db_q;
    logic [DEB_W-1:0] deb_cnt;
    logic             start_rise;

    state_t            state,      state_nxt;
    logic [WIDTH-1:0]  shreg,      shreg_nxt;
    logic [TICK_W-1:0] tick_cnt,   tick_nxt;
    logic [IDX_W-1:0]  idx,        idx_nxt;
    logic              serial_q,   serial_nxt;
    logic              bit_valid_q, bit_valid_nxt;
    logic              busy_q,     busy_nxt;
    logic              done_q,     done_nxt;
    logic              load;

    // The debounced level only follows the synchronised button after it has
    // disagreed for DEB_CYCLES consecutive clocks; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_s_n) begin
            sync_ff    <= 1'b0;
            start_sync <= 1'b0;
            start_db   <= 1'b0;
            start_db_q <= 1'b0;
            deb_cnt    <= '0;
        end else begin
            sync_ff    <= ser.start_btn;
            start_sync <= sync_ff;
            start_db_q <= start_db;
            if (start_sync == start_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                start_db <= start_sync;
                deb_cnt  <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    assign start_rise = start_db & ~start_db_q;

    always_ff @(posedge clk) begin
        if (!rst_s_n) begin
            state       <= IDLE;
            shreg       <= '0;
            tick_cnt    <= '0;
            idx         <= '0;
            serial_q    <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            tick_cnt    <= tick_nxt;
            idx         <= idx_nxt;
            serial_q    <= serial_nxt;
            bit_valid_q <= bit_valid_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
        end
    end

    // A load (from IDLE on a press, or from DONE when looping) is shared so both
    // entry paths present the MSB with its bit_valid on the very next clock.
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        tick_nxt      = tick_cnt;
        idx_nxt       = idx;
        serial_nxt    = serial_q;
        bit_valid_nxt = 1'b0;
        busy_nxt      = busy_q;
        done_nxt      = 1'b0;
        load          = 1'b0;

        case (state)
            IDLE: begin
                if (start_rise) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_nxt = '0;
                    if (idx < IDX_LAST) begin
                        idx_nxt       = idx + IDX_W'(1);
                        serial_nxt    = shreg[WIDTH-2];
                        shreg_nxt     = shreg << 1;
                        bit_valid_nxt = 1'b1;
                    end else begin
                        state_nxt  = DONE;
                        done_nxt   = 1'b1;
                        busy_nxt   = 1'b0;
                        serial_nxt = 1'b0;
                        idx_nxt    = '0;
                    end
                end else begin
                    tick_nxt = tick_cnt + TICK_W'(1);
                end
            end
            DONE: begin
                if (ser.loop_en) begin
                    load = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (load) begin
            state_nxt     = SHIFT;
            shreg_nxt     = ser.pattern_in;
            serial_nxt    = ser.pattern_in[WIDTH-1];
            bit_valid_nxt = 1'b1;
            busy_nxt      = 1'b1;
            idx_nxt       = '0;
            tick_nxt      = '0;
        end
    end

    assign ser.serial_out = serial_q;
    assign ser.bit_valid  = bit_valid_q;
    assign ser.busy       = busy_q;
    assign ser.done       = done_q;
    assign ser.bit_idx    = 4'(idx);

    a_no_valid_with_done: assert property (@(posedge clk) disable iff (!rst_s_n)
        !(bit_valid_q && done_q));

    a_busy_is_shift: assert property (@(posedge clk) disable iff (!rst_s_n)
        busy_q == (state == SHIFT));
endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer with WIDTH=4, TICK_DIV=3, DEB_CYCLES=4.
// A monitor logs every presented bit, done pulse and busy cycle; each test checks that log.
module tb_seq_serializer;
    localparam int W  = 4;
    localparam int TD = 3;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst_s_n;

    always #5 clk = ~clk;

    seq_serializer_if #(.WIDTH(W)) ser ();

    seq_serializer #(
        .WIDTH      (W),
        .TICK_DIV   (TD),
        .DEB_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .rst_s_n (rst_s_n),
        .ser     (ser)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int   cyc = 0;
    logic mon_bits[$];
    int   mon_idx[$];
    int   mon_vt[$];
    int   mon_done_t[$];
    logic mon_ser[$];
    int   busy_cnt = 0;
    bit   overlap = 1'b0;

    // Samples 2 time units after each rising edge, well clear of the edge and of
    // the falling edge where the tests drive inputs.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (ser.bit_valid === 1'b1) begin
            mon_bits.push_back(ser.serial_out);
            mon_idx.push_back(int'(ser.bit_idx));
            mon_vt.push_back(cyc);
        end
        if (ser.done === 1'b1) mon_done_t.push_back(cyc);
        if (ser.busy === 1'b1) begin
            busy_cnt++;
            mon_ser.push_back(ser.serial_out);
        end
        if (ser.bit_valid === 1'b1 && ser.done === 1'b1) overlap = 1'b1;
    end

    task automatic clear_log();
        mon_bits.delete();
        mon_idx.delete();
        mon_vt.delete();
        mon_done_t.delete();
        mon_ser.delete();
        busy_cnt = 0;
        overlap  = 1'b0;
    endtask

    // Drives start_btn high during up to two windows [a, a+h) counted in cycles.
    task automatic run_cycles(input int n, input int a1, input int h1, input int a2, input int h2);
        for (int k = 0; k < n; k++) begin
            ser.start_btn = ((k >= a1) && (k < a1 + h1)) || ((k >= a2) && (k < a2 + h2));
            @(negedge clk);
        end
        ser.start_btn = 1'b0;
    endtask

    function automatic logic [15:0] pack_bits(input int n);
        logic [15:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[14:0], (i < mon_bits.size()) ? mon_bits[i] : 1'bx};
        return r;
    endfunction

    function automatic logic [15:0] pack_ser(input int n);
        logic [15:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[14:0], (i < mon_ser.size()) ? mon_ser[i] : 1'bx};
        return r;
    endfunction

    function automatic logic [15:0] pack_idx();
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) r = {r[11:0], (i < mon_idx.size()) ? 4'(mon_idx[i]) : 4'bxxxx};
        return r;
    endfunction

    function automatic logic [7:0] out_vec();
        return {ser.serial_out, ser.bit_valid, ser.busy, ser.done, ser.bit_idx};
    endfunction

    task automatic test_reset();
        int lat;
        ser.start_btn  = 1'b1;
        ser.pattern_in = '0;
        ser.loop_en    = 1'b0;
        rst_s_n        = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_vec() !== 8'h00) begin
                n_bad++;
                $display("[TB] FAIL t1_reset_outputs cycle %0d: got %h, expected 00", k, out_vec());
            end
        end
        clear_log();
        rst_s_n = 1'b1;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ser.bit_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_cmp++;
        if (lat < 1) begin
            n_bad++;
            $display("[TB] FAIL t1_first_bit_latency: got no bit_valid within 8 clk, expected <= 8");
        end
        ser.start_btn = 1'b0;
        repeat (25) @(negedge clk);
        n_cmp++;
        if (out_vec() !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL t1_idle_after_pass: got %h, expected 00", out_vec());
        end
    endtask

    task automatic test_basic();
        int c0;
        clear_log();
        ser.pattern_in = 4'b1011;
        ser.loop_en    = 1'b0;
        c0 = cyc;
        run_cycles(30, 0, 4, -1, 0);
        n_cmp++;
        if (mon_vt.size() != 4) begin
            n_bad++;
            $display("[TB] FAIL t2_bit_count: got %0d, expected 4", mon_vt.size());
        end
        n_cmp++;
        if ((mon_vt.size() > 0 ? mon_vt[0] - c0 : -1) !== 7) begin
            n_bad++;
            $display("[TB] FAIL t2_press_latency: got %0d, expected 7", mon_vt.size() > 0 ? mon_vt[0] - c0 : -1);
        end
        n_cmp++;
        if (pack_bits(4) !== 16'b1011) begin
            n_bad++;
            $display("[TB] FAIL t2_bits: got %b, expected 1011", pack_bits(4));
        end
        n_cmp++;
        if (pack_idx() !== 16'h0123) begin
            n_bad++;
            $display("[TB] FAIL t2_bit_idx: got %h, expected 0123", pack_idx());
        end
        if (mon_vt.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (mon_vt[i] - mon_vt[i-1] !== TD) begin
                    n_bad++;
                    $display("[TB] FAIL t2_bit_spacing %0d: got %0d, expected %0d", i, mon_vt[i] - mon_vt[i-1], TD);
                end
            end
        end
        n_cmp++;
        if (pack_ser(12) !== 16'b1110_0011_1111) begin
            n_bad++;
            $display("[TB] FAIL t2_serial_trace: got %b, expected 111000111111", pack_ser(12));
        end
        n_cmp++;
        if (busy_cnt !== 12) begin
            n_bad++;
            $display("[TB] FAIL t2_busy_cycles: got %0d, expected 12", busy_cnt);
        end
        n_cmp++;
        if (mon_done_t.size() !== 1) begin
            n_bad++;
            $display("[TB] FAIL t2_done_count: got %0d, expected 1", mon_done_t.size());
        end
        n_cmp++;
        if ((mon_done_t.size() > 0 && mon_vt.size() > 0 ? mon_done_t[0] - mon_vt[0] : -1) !== 12) begin
            n_bad++;
            $display("[TB] FAIL t2_done_position: got %0d, expected 12",
                     mon_done_t.size() > 0 && mon_vt.size() > 0 ? mon_done_t[0] - mon_vt[0] : -1);
        end
        n_cmp++;
        if (out_vec() !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL t2_idle_after_done: got %h, expected 00", out_vec());
        end
        n_cmp++;
        if (overlap !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL t2_valid_done_overlap: got 1, expected 0");
        end
    endtask

    task automatic test_bounce();
        logic bounce[17] = '{1, 0, 1, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        clear_log();
        ser.pattern_in = 4'b0110;
        for (int i = 0; i < 17; i++) begin
            ser.start_btn = bounce[i];
            @(negedge clk);
        end
        n_cmp++;
        if (mon_vt.size() !== 0 || busy_cnt !== 0) begin
            n_bad++;
            $display("[TB] FAIL t3_bounce_rejected: got %0d bits / %0d busy, expected 0 / 0", mon_vt.size(), busy_cnt);
        end
        clear_log();
        run_cycles(30, 0, 6, -1, 0);
        n_cmp++;
        if (mon_vt.size() !== 4 || mon_done_t.size() !== 1) begin
            n_bad++;
            $display("[TB] FAIL t3_single_pass: got %0d bits / %0d done, expected 4 / 1", mon_vt.size(), mon_done_t.size());
        end
        n_cmp++;
        if (pack_bits(4) !== 16'b0110) begin
            n_bad++;
            $display("[TB] FAIL t3_bits: got %b, expected 0110", pack_bits(4));
        end
    endtask

    task automatic test_ignore();
        clear_log();
        ser.pattern_in = 4'b1011;
        run_cycles(35, 0, 4, 10, 4);
        n_cmp++;
        if (mon_vt.size() !== 4 || mon_done_t.size() !== 1 || busy_cnt !== 12) begin
            n_bad++;
            $display("[TB] FAIL t4_press_mid_shift: got %0d bits / %0d done / %0d busy, expected 4 / 1 / 12",
                     mon_vt.size(), mon_done_t.size(), busy_cnt);
        end
        n_cmp++;
        if (pack_bits(4) !== 16'b1011) begin
            n_bad++;
            $display("[TB] FAIL t4_bits_mid_shift: got %b, expected 1011", pack_bits(4));
        end
        clear_log();
        ser.pattern_in = 4'b1001;
        run_cycles(35, 0, 4, 13, 4);
        n_cmp++;
        if (mon_vt.size() !== 4 || mon_done_t.size() !== 1) begin
            n_bad++;
            $display("[TB] FAIL t4_press_on_done: got %0d bits / %0d done, expected 4 / 1", mon_vt.size(), mon_done_t.size());
        end
        n_cmp++;
        if (pack_bits(4) !== 16'b1001) begin
            n_bad++;
            $display("[TB] FAIL t4_bits_on_done: got %b, expected 1001", pack_bits(4));
        end
    endtask

    task automatic test_loop();
        clear_log();
        ser.pattern_in = 4'b1100;
        ser.loop_en    = 1'b1;
        for (int k = 0; k < 50; k++) begin
            ser.start_btn = (k < 4);
            if (k == 10) ser.pattern_in = 4'b0110;
            if (k == 25) ser.loop_en = 1'b0;
            @(negedge clk);
        end
        ser.start_btn = 1'b0;
        n_cmp++;
        if (mon_vt.size() !== 8) begin
            n_bad++;
            $display("[TB] FAIL t5_bit_count: got %0d, expected 8", mon_vt.size());
        end
        n_cmp++;
        if (pack_bits(8) !== 16'b1100_0110) begin
            n_bad++;
            $display("[TB] FAIL t5_bits: got %b, expected 11000110", pack_bits(8));
        end
        n_cmp++;
        if (mon_done_t.size() !== 2) begin
            n_bad++;
            $display("[TB] FAIL t5_done_count: got %0d, expected 2", mon_done_t.size());
        end
        n_cmp++;
        if ((mon_vt.size() > 4 && mon_done_t.size() > 0 ? mon_vt[4] - mon_done_t[0] : -1) !== 1) begin
            n_bad++;
            $display("[TB] FAIL t5_reload_gap: got %0d, expected 1",
                     mon_vt.size() > 4 && mon_done_t.size() > 0 ? mon_vt[4] - mon_done_t[0] : -1);
        end
        n_cmp++;
        if (busy_cnt !== 24 || overlap !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL t5_busy_overlap: got %0d busy / overlap %0b, expected 24 / 0", busy_cnt, overlap);
        end
        n_cmp++;
        if (out_vec() !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL t5_idle_after_loop: got %h, expected 00", out_vec());
        end
    endtask

    task automatic test_abort();
        bit found = 1'b0;
        clear_log();
        ser.pattern_in = 4'b1011;
        ser.loop_en    = 1'b0;
        for (int k = 0; k < 30; k++) begin
            ser.start_btn = (k < 4);
            @(negedge clk);
            if (ser.bit_idx === 4'd2) begin
                found = 1'b1;
                break;
            end
        end
        ser.start_btn = 1'b0;
        n_cmp++;
        if (found !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL t6_reach_idx2: got no bit_idx=2 within 30 clk, expected it");
        end
        rst_s_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_vec() !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL t6_abort_outputs: got %h, expected 00", out_vec());
        end
        rst_s_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (mon_vt.size() !== 3 || mon_done_t.size() !== 0 || ser.busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL t6_no_resume: got %0d bits / %0d done / busy %b, expected 3 / 0 / 0",
                     mon_vt.size(), mon_done_t.size(), ser.busy);
        end
        clear_log();
        run_cycles(30, 0, 4, -1, 0);
        n_cmp++;
        if (mon_vt.size() !== 4 || mon_done_t.size() !== 1 || pack_bits(4) !== 16'b1011) begin
            n_bad++;
            $display("[TB] FAIL t6_new_press: got %0d bits / %0d done / %b, expected 4 / 1 / 1011",
                     mon_vt.size(), mon_done_t.size(), pack_bits(4));
        end
    endtask

    initial begin
        rst_s_n        = 1'b0;
        ser.start_btn  = 1'b0;
        ser.pattern_in = '0;
        ser.loop_en    = 1'b0;
        $display("[TB] seq_serializer bench start");
        test_reset();
        test_basic();
        test_bounce();
        test_ignore();
        test_loop();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
